// File: rtl/calc_disp_pkg.sv
// Shared types, segment patterns and the BCD digit decoder for the calculator display driver.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package calc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Five digits cover the 14-bit maximum of 16383.
    localparam int unsigned BCD_DIGITS  = 5;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned DISP_DIGITS = 4;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        unique case (digit)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Free-running iterative double-dabble converter: IDLE -> LOAD -> SHIFT x VAL_W -> DONE.
// bcd_o is stable and final while conv_done_o is high.
module bin2bcd_seq
    import calc_disp_pkg::*;
#(
    parameter int unsigned VAL_W = 14
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [VAL_W-1:0] value_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             conv_done_o
);

    localparam int unsigned CNT_W = $clog2(VAL_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(VAL_W - 1);

    conv_state_t      state_q, state_d;
    logic [VAL_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_en, shift_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_ITER) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_en     = (state_q == LOAD);
        shift_en    = (state_q == SHIFT);
        conv_done_o = (state_q == DONE);
    end

    // Add-3 stays within each nibble; a nibble <= 9 never carries out.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (load_en) begin
            bin_d = value_i;
            bcd_d = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/calc_display_driver.sv
// Selects one calculator operand, converts it to BCD and scans it onto four active-low
// 7-segment digits with leading-zero blanking and a dash pattern for values above 9999.
module calc_display_driver
    import calc_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned VAL_W    = 14
) (
    input  logic             clk,
    input  logic             rst_ext,
    input  logic [VAL_W-1:0] number_1,
    input  logic [VAL_W-1:0] number_2,
    input  logic             write_number_select,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp,
    output logic             ovf,
    output logic             conv_done
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    logic [VAL_W-1:0]            operand;
    logic [BCD_W-1:0]            bcd;
    logic [DISP_DIGITS-1:0][3:0] digit_q;
    logic                        ovf_q;
    logic                        disp_valid_q;
    logic [PRE_W-1:0]            presc_q;
    logic                        presc_wrap;
    logic [1:0]                  idx_q;
    logic [DISP_DIGITS-1:0]      shown;
    logic [6:0]                  seg_q, seg_d;
    logic [3:0]                  an_q, an_d;
    logic                        dp_q, dp_d;

    assign operand = write_number_select ? number_2 : number_1;

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk_i       (clk),
        .rst_i       (rst_ext),
        .value_i     (operand),
        .bcd_o       (bcd),
        .conv_done_o (conv_done)
    );

    // Display registers only move on a finished conversion; the valid flag keeps the
    // panel dark from reset until the first result lands.
    always_ff @(posedge clk) begin
        if (rst_ext) begin
            digit_q      <= '0;
            ovf_q        <= 1'b0;
            disp_valid_q <= 1'b0;
        end else if (conv_done) begin
            digit_q      <= bcd[4*DISP_DIGITS-1:0];
            ovf_q        <= |bcd[BCD_W-1:4*DISP_DIGITS];
            disp_valid_q <= 1'b1;
        end
    end

    assign presc_wrap = (presc_q == PRE_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_wrap ? '0 : presc_q + PRE_W'(1);
            if (presc_wrap) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    // A digit is shown if it or any more significant digit is nonzero; units always shown.
    always_comb begin
        logic any_nz;
        any_nz   = 1'b0;
        shown    = '0;
        shown[0] = 1'b1;
        for (int k = DISP_DIGITS - 1; k >= 1; k--) begin
            any_nz   = any_nz | (digit_q[k] != 4'd0);
            shown[k] = any_nz;
        end
    end

    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        dp_d  = ~((idx_q == 2'd0) & write_number_select);
        seg_d = SEG_BLANK;
        if (!disp_valid_q) begin
            an_d = 4'hF;
            dp_d = 1'b1;
        end else if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (shown[idx_q]) begin
            seg_d = seg_decode(digit_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ext) begin
            seg_q <= SEG_BLANK;
            an_q  <= 4'hF;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// Scoreboard bench for calc_display_driver: stimulus queues the operand each conversion
// should capture; a monitor checks every scanned digit against a decimal reference model.
module tb_calc_display_driver;

    localparam int unsigned SCAN_DIV = 4;
    localparam int          PERIOD   = 17;

    logic        clk = 1'b0;
    logic        rst_ext = 1'b1;
    logic [13:0] number_1 = '0;
    logic [13:0] number_2 = '0;
    logic        write_number_select = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        ovf;
    logic        conv_done;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int cyc = 0;
    logic rst_at_edge;
    logic sel_at_edge;

    calc_display_driver #(
        .SCAN_DIV (SCAN_DIV),
        .VAL_W    (14)
    ) dut (
        .clk                 (clk),
        .rst_ext             (rst_ext),
        .number_1            (number_1),
        .number_2            (number_2),
        .write_number_select (write_number_select),
        .seg                 (seg),
        .an                  (an),
        .dp                  (dp),
        .ovf                 (ovf),
        .conv_done           (conv_done)
    );

    always #5 clk = ~clk;

    // What the DUT saw at the most recent active edge.
    always @(posedge clk) begin
        rst_at_edge <= rst_ext;
        sel_at_edge <= write_number_select;
        cyc         <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int digit_pattern(input int d);
        case (d)
            0: return 'h40;
            1: return 'h79;
            2: return 'h24;
            3: return 'h30;
            4: return 'h19;
            5: return 'h12;
            6: return 'h02;
            7: return 'h78;
            8: return 'h00;
            default: return 'h10;
        endcase
    endfunction

    // Decimal view of the value: dash above 9999, leading zeros blank, units always lit.
    function automatic int model_seg(input int val, input int idx);
        int p = 1;
        if (val > 9999) return 'h3F;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (idx > 0 && val < p) return 'h7F;
        return digit_pattern((val / p) % 10);
    endfunction

    function automatic int an_idx(input logic [3:0] a);
        case (a)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    initial begin : monitor
        int  cur_val, pend_val, sw, last_done, prev_idx, dwell, idx;
        bit  cur_valid, dwell_known;
        int  exp_ovf;
        cur_val = 0; pend_val = 0; sw = 0; last_done = -1;
        prev_idx = -1; dwell = 0; cur_valid = 0; dwell_known = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                check("reset seg", seg, 'h7F);
                check("reset an", an, 'hF);
                check("reset dp", dp, 1);
                check("reset ovf", ovf, 0);
                check("reset conv_done", conv_done, 0);
                cur_valid = 0; sw = 0; last_done = -1; prev_idx = -1; dwell_known = 0;
                continue;
            end
            if (sw > 0) begin
                sw--;
                if (sw == 0) begin
                    cur_val   = pend_val;
                    cur_valid = 1;
                end
            end
            exp_ovf = (sw == 1) ? int'(pend_val > 9999) : int'(cur_valid && cur_val > 9999);
            check("ovf", ovf, exp_ovf);
            if (!cur_valid) begin
                check("blank seg", seg, 'h7F);
                check("blank an", an, 'hF);
                check("blank dp", dp, 1);
                prev_idx    = -1;
                dwell_known = 0;
            end else begin
                idx = an_idx(an);
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL an one-hot: got %0h, expected one of E/D/B/7 (t=%0t)", an, $time);
                end else begin
                    check($sformatf("seg val=%0d digit=%0d", cur_val, idx), seg,
                          model_seg(cur_val, idx));
                    check("dp", dp, (idx == 0 && sel_at_edge) ? 0 : 1);
                    if (idx == prev_idx) begin
                        dwell++;
                    end else begin
                        if (prev_idx >= 0) begin
                            check("scan order", idx, (prev_idx + 1) % 4);
                            if (dwell_known) check("scan dwell", dwell, SCAN_DIV);
                            dwell_known = 1;
                        end
                        prev_idx = idx;
                        dwell    = 1;
                    end
                end
            end
            if (conv_done) begin
                if (last_done >= 0) check("conv period", cyc - last_done, PERIOD);
                last_done = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: conv_done with nothing expected (t=%0t)", $time);
                end else begin
                    pend_val = exp_q.pop_front();
                    sw       = 2;
                end
            end
        end
    end

    // Waits for the end of a conversion, then presents the operands for the next LOAD.
    task automatic next_conv(input int n1, input int n2, input bit sel, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!conv_done && waited < 40);
        if (!conv_done) begin
            checks++;
            errors++;
            $display("FAIL conv_done timeout: none within %0d cycles", waited);
        end
        #1;
        number_1            = 14'(n1);
        number_2            = 14'(n2);
        write_number_select = sel;
        exp_q.push_back(sel ? n2 : n1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w, lim, n1, n2;
        bit sel;
        repeat (3) @(negedge clk);
        #1 rst_ext = 1'b0;
        exp_q.push_back(0);

        next_conv(1234, 0, 0, w);
        checks++;
        if (w < 16 || w > 17) begin
            errors++;
            $display("FAIL first conv latency: got %0d cycles, expected 16..17", w);
        end
        next_conv(1234, 507, 1, w);
        next_conv(16383, 507, 0, w);
        next_conv(10000, 3, 0, w);
        next_conv(9999, 3, 0, w);
        next_conv(5, 60, 1, w);
        next_conv(700, 60, 0, w);
        next_conv(700, 0, 1, w);

        for (int i = 0; i < 20; i++) begin
            lim = (i % 4 == 0) ? 16383 : (i % 4 == 1) ? 99 : (i % 4 == 2) ? 999 : 9999;
            n1  = $urandom_range(0, lim);
            n2  = $urandom_range(0, lim);
            sel = 1'($urandom % 2);
            next_conv(n1, n2, sel, w);
        end

        // Operand changes during SHIFT must not disturb the conversion in flight.
        next_conv(42, 0, 0, w);
        repeat (3) @(negedge clk);
        #1 number_1 = 14'd99;
        next_conv(99, 0, 0, w);
        next_conv(99, 0, 0, w);

        // Reset in the middle of SHIFT while 8888 is on the panel.
        next_conv(8888, 0, 0, w);
        next_conv(8888, 0, 0, w);
        repeat (8) @(negedge clk);
        #1;
        rst_ext  = 1'b1;
        exp_q.delete();
        number_1 = 14'd321;
        write_number_select = 1'b0;
        @(negedge clk);
        #1 rst_ext = 1'b0;
        exp_q.push_back(321);
        next_conv(321, 4321, 1, w);
        next_conv(321, 4321, 1, w);
        next_conv(2, 4321, 0, w);

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
